alu_pipe: RTL and testbench



---
 rtl/alu_pipe_pkg.sv | 23 ++
 rtl/alu_pipe_cla_adder.sv | 61 ++++++
 rtl/alu_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encoding and helpers shared by the alu_pipe slice.
//   opcode_t      3-bit operation select
//   OP_NOP..OP_ORA opcode constants (bit 2 selects ACC as operand A)
//   is_acc_op()   true for the ops that write the accumulator
package alu_pipe_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NOP  = 3'b000;
    localparam opcode_t OP_ADD  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_SLT  = 3'b100;
    localparam opcode_t OP_ADDA = 3'b101;
    localparam opcode_t OP_ANDA = 3'b110;
    localparam opcode_t OP_ORA  = 3'b111;

    // SLT reads ACC but does not write it back.
    function automatic logic is_acc_op(input opcode_t op);
        return op[2] && (op != OP_SLT);
    endfunction

endpackage

// File: rtl/alu_pipe_cla_adder.sv
// cla_adder: purely combinational carry-lookahead adder.
//   Bits are grouped CLA_GROUP at a time; each group produces a group
//   generate/propagate pair and the group carries chain from group to group.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry in
//   sum   out WIDTH  a + b + cin (mod 2^WIDTH)
//   cout  out 1      carry out of the top bit
module cla_adder #(
    parameter int WIDTH     = 16,
    parameter int CLA_GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGRP = WIDTH / CLA_GROUP;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic [NGRP-1:0]  grp_gen;
    logic [NGRP-1:0]  grp_prop;
    logic             term;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        carry    = '0;
        grp_gen  = '0;
        grp_prop = '0;
        term     = 1'b0;
        carry[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            // Group generate/propagate from the bit-level terms.
            grp_prop[k] = 1'b1;
            grp_gen[k]  = 1'b0;
            for (int m = 0; m < CLA_GROUP; m++) begin
                grp_gen[k]  = gen[k*CLA_GROUP+m] | (prop[k*CLA_GROUP+m] & grp_gen[k]);
                grp_prop[k] = grp_prop[k] & prop[k*CLA_GROUP+m];
            end
            // Internal carries are expanded from the group's carry-in only.
            for (int j = 1; j < CLA_GROUP; j++) begin
                term = carry[k*CLA_GROUP];
                for (int m = 0; m < j; m++) begin
                    term = gen[k*CLA_GROUP+m] | (prop[k*CLA_GROUP+m] & term);
                end
                carry[k*CLA_GROUP+j] = term;
            end
            carry[(k+1)*CLA_GROUP] = grp_gen[k] | (grp_prop[k] & carry[k*CLA_GROUP]);
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with an accumulator.
//   S1 registers X/Y/OPCODE; S2 computes and registers RESULTS/CF.
//   Optional zero flag output when ALU_PIPE_ZF_EN is defined.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand beat handshake
//   x, y, opcode        operands and operation select
//   acc_clr             synchronous accumulator clear (handshake independent)
//   out_valid/out_ready result beat handshake
//   results, cf         result and carry/compare flag
//   acc                 current accumulator value
//   zf                  (ALU_PIPE_ZF_EN only) results == 0 for the beat
//
// Stage state (per stage valid bit):
//   state | meaning
//   EMPTY | valid bit 0, stage holds no beat
//   FULL  | valid bit 1, stage holds a beat waiting to advance
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CLA_GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  opcode_t          opcode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] results,
    output logic             cf,
    output logic [WIDTH-1:0] acc
`ifdef ALU_PIPE_ZF_EN
    ,
    output logic             zf
`endif
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    opcode_t          s1_op;

    logic             s2_adv;
    logic             s2_beat;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             slt_lt;
    logic [WIDTH-1:0] s2_res;
    logic             s2_cf;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    // NOPs occupy S1 but never become an output beat.
    assign s2_beat  = s1_valid && (s1_op != OP_NOP);

    assign opnd_a = s1_op[2] ? acc : s1_x;
    assign slt_lt = (acc < s1_y);

    cla_adder #(
        .WIDTH    (WIDTH),
        .CLA_GROUP(CLA_GROUP)
    ) u_cla (
        .a   (opnd_a),
        .b   (s1_y),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_comb begin
        s2_res = '0;
        s2_cf  = 1'b0;
        case (s1_op)
            OP_ADD, OP_ADDA: begin
                s2_res = add_sum;
                s2_cf  = add_cout;
            end
            OP_AND, OP_ANDA: s2_res = opnd_a & s1_y;
            OP_OR,  OP_ORA:  s2_res = opnd_a | s1_y;
            OP_SLT: begin
                s2_res = {{(WIDTH-1){1'b0}}, slt_lt};
                s2_cf  = slt_lt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_op    <= OP_NOP;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x  <= x;
                s1_y  <= y;
                s1_op <= opcode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            results   <= '0;
            cf        <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s2_beat;
            if (s2_beat) begin
                results <= s2_res;
                cf      <= s2_cf;
            end
        end
    end

`ifdef ALU_PIPE_ZF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b0;
        end else if (s2_adv && s2_beat) begin
            zf <= (s2_res == '0);
        end
    end
`endif

    // A clear in the same cycle as an accumulator write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (s2_adv && s1_valid && is_acc_op(s1_op)) begin
            acc <= s2_res;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  opcode;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] results;
    logic        cf;
    logic [15:0] acc;
`ifdef ALU_PIPE_ZF_EN
    logic        zf;
`endif

    alu_pipe #(.WIDTH(16), .CLA_GROUP(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .opcode   (opcode),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .results  (results),
        .cf       (cf),
        .acc      (acc)
`ifdef ALU_PIPE_ZF_EN
        ,
        .zf       (zf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          n_out = 0;
    logic [15:0] model_acc = '0;
    logic [15:0] exp_r[$];
    logic        exp_c[$];
    logic        s_in_ready, s_out_valid, s_accept;
    logic        stall_prev = 1'b0;
    logic [15:0] held_r;
    logic        held_c;
    logic [15:0] last_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: beats take effect in acceptance order; ACC is the running
    // value produced by all earlier accumulator-writing beats.
    task automatic model_accept(input logic [2:0] op, input logic [15:0] xa, input logic [15:0] yb);
        logic [16:0] s;
        logic [15:0] a, r;
        logic        c;
        a = op[2] ? model_acc : xa;
        r = '0;
        c = 1'b0;
        case (op)
            3'd1, 3'd5: begin s = {1'b0, a} + {1'b0, yb}; r = s[15:0]; c = s[16]; end
            3'd2, 3'd6: r = a & yb;
            3'd3, 3'd7: r = a | yb;
            3'd4: begin c = (model_acc < yb); r = {15'd0, c}; end
            default: ;
        endcase
        if (op != 3'd0) begin
            exp_r.push_back(r);
            exp_c.push_back(c);
        end
        if (op == 3'd5 || op == 3'd6 || op == 3'd7) model_acc = r;
    endtask

    // One clock: sample 1 ns after the negedge, then wait for the next negedge.
    task automatic cycle();
        logic [15:0] er;
        logic        ec;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_accept    = in_valid && in_ready;
        if (stall_prev && out_valid) begin
            chk("hold_results", 32'(results), 32'(held_r));
            chk("hold_cf", 32'(cf), 32'(held_c));
        end
        if (out_valid && out_ready) begin
            if (exp_r.size() == 0) begin
                chk("spurious_beat", 32'(out_valid), 32'd0);
            end else begin
                er = exp_r.pop_front();
                ec = exp_c.pop_front();
                chk("beat_results", 32'(results), 32'(er));
                chk("beat_cf", 32'(cf), 32'(ec));
`ifdef ALU_PIPE_ZF_EN
                chk("beat_zf", 32'(zf), 32'(er == 16'd0));
`endif
                last_r = results;
                n_out++;
            end
        end
        stall_prev = out_valid && !out_ready;
        held_r     = results;
        held_c     = cf;
        if (acc_clr) model_acc = '0;
        if (s_accept) model_accept(opcode, x, y);
        @(negedge clk);
    endtask

    task automatic beat(input logic [2:0] op, input logic [15:0] xa, input logic [15:0] yb);
        in_valid = 1'b1;
        opcode   = op;
        x        = xa;
        y        = yb;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && exp_r.size() > 0; t++) cycle();
        chk("drain_timeout", 32'(exp_r.size()), 32'd0);
        cycle();
        cycle();
    endtask

    int idx;
    int n0;
    logic drop_seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; opcode = '0;
        acc_clr = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_results", 32'(results), 32'd0);
        chk("rst_cf", 32'(cf), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
`ifdef ALU_PIPE_ZF_EN
        chk("rst_zf", 32'(zf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rst_in_ready", 32'(s_in_ready), 32'd1);

        // Load ACC, then reset with a beat in flight.
        beat(3'd5, 16'h0, 16'h1234);
        drain();
        chk("acc_loaded", 32'(acc), 32'h1234);
        beat(3'd1, 16'h0011, 16'h0022);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_acc", 32'(acc), 32'd0);
        chk("midrst_results", 32'(results), 32'd0);
        exp_r.delete(); exp_c.delete();
        model_acc = '0; stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 4; i++) cycle();
        chk("midrst_no_beat", 32'(n_out - n0), 32'd0);
        chk("midrst_in_ready", 32'(s_in_ready), 32'd1);

        // ADD wrap with latency check.
        beat(3'd1, 16'hFFFF, 16'h0001);
        cycle();
        chk("lat_not_yet", 32'(s_out_valid), 32'd0);
        cycle();
        chk("lat_two", 32'(s_out_valid), 32'd1);
        chk("wrap_result", 32'(last_r), 32'd0);
        drain();

        // Accumulator chain.
        acc_clr = 1'b1; cycle(); acc_clr = 1'b0;
        in_valid = 1'b1;
        opcode = 3'd5; y = 16'd5;     cycle();
        opcode = 3'd5; y = 16'd7;     cycle();
        opcode = 3'd6; y = 16'h000C;  cycle();
        drain();
        chk("chain_acc", 32'(acc), 32'h000C);

        // SLT, NOP, OR: two output beats only.
        acc_clr = 1'b1; cycle(); acc_clr = 1'b0;
        beat(3'd5, 16'h0, 16'd3);
        drain();
        n0 = n_out;
        in_valid = 1'b1;
        opcode = 3'd4; x = 16'h0;    y = 16'd4;    cycle();
        opcode = 3'd0; x = 16'h5555; y = 16'h5555; cycle();
        opcode = 3'd3; x = 16'h00F0; y = 16'h0F00; cycle();
        drain();
        chk("slt_nop_beats", 32'(n_out - n0), 32'd2);
        chk("slt_nop_last", 32'(last_r), 32'h0FF0);
        chk("slt_nop_acc", 32'(acc), 32'd3);

        // Backpressure: OUT_READY low for the first 3 cycles.
        idx = 0; drop_seen = 1'b0;
        for (int t = 0; t < 30 && idx < 4; t++) begin
            out_ready = (t >= 3);
            in_valid  = 1'b1;
            opcode    = 3'd1;
            x         = 16'(idx * 16'h1111);
            y         = 16'h0101;
            cycle();
            if (!s_in_ready && !drop_seen) begin
                drop_seen = 1'b1;
                chk("bp_accepts_before_drop", 32'(idx), 32'd2);
            end
            if (s_accept) idx++;
        end
        chk("bp_in_ready_dropped", 32'(drop_seen), 32'd1);
        chk("bp_all_accepted", 32'(idx), 32'd4);
        n0 = n_out - 4;
        drain();

        // Clear colliding with an ADDA capture: ACC was 3.
        beat(3'd5, 16'h0, 16'd9);
        acc_clr = 1'b1; cycle(); acc_clr = 1'b0;
        drain();
        chk("collide_result", 32'(last_r), 32'd12);
        chk("collide_acc", 32'(acc), 32'd0);

        // Random traffic with random backpressure.
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            opcode    = 3'($urandom_range(0, 7));
            x         = 16'($urandom);
            y         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            cycle();
        end
        drain();
        chk("rand_acc", 32'(acc), 32'(model_acc));
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
